// File: rtl/bin_avg_pkg.sv
// Shared types and helpers for the FFT bin averaging sequencer.
package bin_avg_pkg;

  localparam int unsigned BINS_DEF     = 4;
  localparam int unsigned N_AVGS_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    COLLECT  = 2'd2,
    HOLD     = 2'd3
  } state_e;

  // Number of frames in one averaging set for a log2 depth of n.
  function automatic int unsigned frames_total(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/bin_frame_counter.sv
// Bin position within the current frame and completed-frame count within the set.
// r_bin_cnt holds the index of the next bin to emit; 0 means the frame is done
// and the sequencer is waiting for the next start-of-frame.
module bin_frame_counter
  import bin_avg_pkg::*;
#(
  parameter  int unsigned BINS     = BINS_DEF,
  parameter  int unsigned N_AVGS_W = N_AVGS_W_DEF,
  localparam int unsigned BIN_W    = $clog2(BINS),
  localparam int unsigned FRM_W    = 2 ** N_AVGS_W
) (
  input  logic                clk,
  input  logic                areset_n,
  input  logic                i_start,
  input  logic                i_adv,
  input  logic [N_AVGS_W-1:0] i_shift,
  output logic [BIN_W-1:0]    o_bin_cnt,
  output logic                o_first_frame_c,
  output logic                o_last_bin_c,
  output logic                o_last_frame_c
);

  logic [BIN_W-1:0] r_bin_cnt;
  logic [FRM_W-1:0] r_frame_cnt;

  // Start loads bin 0 as emitted; advance steps the bin and counts frames at the wrap.
  always_ff @(posedge clk) begin
    if (!areset_n) begin
      r_bin_cnt   <= '0;
      r_frame_cnt <= '0;
    end else if (i_start) begin
      r_bin_cnt   <= BIN_W'(1);
      r_frame_cnt <= '0;
    end else if (i_adv) begin
      if (o_last_bin_c) begin
        r_bin_cnt   <= '0;
        r_frame_cnt <= r_frame_cnt + FRM_W'(1);
      end else begin
        r_bin_cnt   <= r_bin_cnt + BIN_W'(1);
      end
    end
  end

  assign o_bin_cnt       = r_bin_cnt;
  assign o_first_frame_c = (r_frame_cnt == '0);
  assign o_last_bin_c    = (r_bin_cnt == BIN_W'(BINS - 1));
  assign o_last_frame_c  = (32'(r_frame_cnt) == (frames_total(32'(i_shift)) - 32'd1));

endmodule

// File: rtl/bin_avg_sequencer.sv
// Frames the FFT bin stream, counts frames per averaging set, drives the
// accumulator controls and holds the averaged result for downstream readout.
module bin_avg_sequencer
  import bin_avg_pkg::*;
#(
  parameter  int unsigned BINS     = BINS_DEF,
  parameter  int unsigned N_AVGS_W = N_AVGS_W_DEF,
  localparam int unsigned BIN_W    = $clog2(BINS)
) (
  input  logic                clk,
  input  logic                areset_n,
  input  logic                enable,
  input  logic                fft_valid,
  input  logic [N_AVGS_W-1:0] n_avgs_in,
  output logic                acc_en,
  output logic                acc_first,
  output logic [BIN_W-1:0]    acc_bin_idx,
  output logic                dump,
  output logic [N_AVGS_W-1:0] shift,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overrun,
  output logic                sof_err
);

  state_e              r_state,     w_nxt_state;
  logic                r_acc_en,    w_acc_en;
  logic                r_acc_first, w_acc_first;
  logic [BIN_W-1:0]    r_acc_bin_idx, w_acc_bin_idx;
  logic                r_dump,      w_dump;
  logic [N_AVGS_W-1:0] r_shift,     w_shift;
  logic                r_out_valid, w_out_valid;
  logic                r_overrun,   w_overrun;
  logic                r_sof_err,   w_sof_err;
  logic                w_start,     w_adv;
  logic [BIN_W-1:0]    w_bin_cnt;
  logic                w_first_frame, w_last_bin, w_last_frame;

  bin_frame_counter #(
    .BINS     (BINS),
    .N_AVGS_W (N_AVGS_W)
  ) u_cnt (
    .clk             (clk),
    .areset_n        (areset_n),
    .i_start         (w_start),
    .i_adv           (w_adv),
    .i_shift         (r_shift),
    .o_bin_cnt       (w_bin_cnt),
    .o_first_frame_c (w_first_frame),
    .o_last_bin_c    (w_last_bin),
    .o_last_frame_c  (w_last_frame)
  );

  // Next state and next values of every registered output.
  always_comb begin
    w_nxt_state   = r_state;
    w_acc_en      = 1'b0;
    w_acc_first   = 1'b0;
    w_acc_bin_idx = '0;
    w_dump        = 1'b0;
    w_shift       = r_shift;
    w_out_valid   = 1'b0;
    w_overrun     = r_overrun;
    w_sof_err     = 1'b0;
    w_start       = 1'b0;
    w_adv         = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) w_nxt_state = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (!enable) begin
          w_nxt_state = IDLE;
        end else if (fft_valid) begin
          w_start     = 1'b1;
          w_shift     = n_avgs_in;
          w_acc_en    = 1'b1;
          w_acc_first = 1'b1;
          w_nxt_state = COLLECT;
        end
      end
      COLLECT: begin
        if (!enable) begin
          w_nxt_state = IDLE;
        end else if (fft_valid && (w_bin_cnt != '0)) begin
          // Start-of-frame inside a frame: restart the set from this frame.
          w_sof_err   = 1'b1;
          w_start     = 1'b1;
          w_shift     = n_avgs_in;
          w_acc_en    = 1'b1;
          w_acc_first = 1'b1;
        end else if (fft_valid || (w_bin_cnt != '0)) begin
          w_adv         = 1'b1;
          w_acc_en      = 1'b1;
          w_acc_first   = w_first_frame;
          w_acc_bin_idx = w_bin_cnt;
          if (w_last_bin && w_last_frame) begin
            w_dump      = 1'b1;
            w_nxt_state = HOLD;
          end
        end
      end
      HOLD: begin
        if (r_out_valid && out_ready) begin
          if (!enable) begin
            w_nxt_state = IDLE;
          end else if (fft_valid) begin
            w_start     = 1'b1;
            w_shift     = n_avgs_in;
            w_acc_en    = 1'b1;
            w_acc_first = 1'b1;
            w_nxt_state = COLLECT;
          end else begin
            w_nxt_state = WAIT_SOF;
          end
        end else begin
          w_out_valid = 1'b1;
          if (fft_valid) w_overrun = 1'b1;
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!areset_n) begin
      r_state       <= IDLE;
      r_acc_en      <= 1'b0;
      r_acc_first   <= 1'b0;
      r_acc_bin_idx <= '0;
      r_dump        <= 1'b0;
      r_shift       <= '0;
      r_out_valid   <= 1'b0;
      r_overrun     <= 1'b0;
      r_sof_err     <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_acc_en      <= w_acc_en;
      r_acc_first   <= w_acc_first;
      r_acc_bin_idx <= w_acc_bin_idx;
      r_dump        <= w_dump;
      r_shift       <= w_shift;
      r_out_valid   <= w_out_valid;
      r_overrun     <= w_overrun;
      r_sof_err     <= w_sof_err;
    end
  end

  assign acc_en      = r_acc_en;
  assign acc_first   = r_acc_first;
  assign acc_bin_idx = r_acc_bin_idx;
  assign dump        = r_dump;
  assign shift       = r_shift;
  assign out_valid   = r_out_valid;
  assign overrun     = r_overrun;
  assign sof_err     = r_sof_err;

endmodule
